tdm_demux_1_4: RTL and testbench

Receive-side companion to the 4:1 mux in Lab-3. Accepts a time-division-multiplexed stream on a single data line, one slot per enabled clock, with a frame marker on slot 0. Recovers the slot sequence, distributes each slot's sample to its own channel, and presents all four channels in parallel once per complete frame. Sits between a TDM link (driven by a mux with a rotating select) and per-channel consumers.

---
 rtl/tdm_demux_1_4.sv | 77 +++++++
 tb/tb_tdm_demux_1_4.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1_4.sv
// Receive side of a 4-slot TDM link: frame recovery on SYNC,
// per-slot shadowing, and parallel frame output on completion.
module tdm_demux_1_4 #(
    parameter int W = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           EN,
    input  logic [W-1:0]   D,
    input  logic           SYNC,
    output logic [4*W-1:0] Y,
    output logic [1:0]     S,
    output logic           VALID,
    output logic           LOCK,
    output logic           ERR
);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]   state;
    logic [W-1:0] sh0;
    logic [W-1:0] sh1;
    logic [W-1:0] sh2;

    assign LOCK = (state == LOCKED);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= HUNT;
            S     <= 2'd0;
            sh0   <= '0;
            sh1   <= '0;
            sh2   <= '0;
            Y     <= '0;
            VALID <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            VALID <= 1'b0;
            ERR   <= 1'b0;
            if (EN) begin
                if (state == HUNT) begin
                    if (SYNC) begin
                        sh0   <= D;
                        S     <= 2'd1;
                        state <= LOCKED;
                    end
                end else begin
                    unique case (1'b1)
                        SYNC: begin
                            // a marker anywhere but slot 0 restarts the frame
                            ERR <= (S != 2'd0);
                            sh0 <= D;
                            S   <= 2'd1;
                        end
                        (!SYNC && S == 2'd0): begin
                            ERR   <= 1'b1;
                            S     <= 2'd0;
                            state <= HUNT;
                        end
                        (!SYNC && S == 2'd3): begin
                            Y     <= {D, sh2, sh1, sh0};
                            VALID <= 1'b1;
                            S     <= 2'd0;
                        end
                        default: begin
                            if (S == 2'd1) sh1 <= D;
                            else           sh2 <= D;
                            S <= S + 2'd1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Bench for tdm_demux_1_4: table-driven directed vectors plus a
// model-driven random stream, all checked through a scoreboard queue.
module tb_tdm_demux_1_4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic       SYNC;
    logic [0:0] D;
    logic [3:0] Y;
    logic [1:0] S;
    logic       VALID;
    logic       LOCK;
    logic       ERR;

    tdm_demux_1_4 #(.W(1)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .D(D), .SYNC(SYNC),
        .Y(Y), .S(S), .VALID(VALID), .LOCK(LOCK), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       en;
        logic       sync;
        logic       d;
        logic [3:0] y;
        logic [1:0] s;
        logic       v;
        logic       l;
        logic       e;
    } vec_t;

    typedef struct {
        logic [3:0] y;
        logic [1:0] s;
        logic       v;
        logic       l;
        logic       e;
        int         id;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // model state for the random phase
    logic       m_lock;
    logic [1:0] m_s;
    logic [2:0] m_sh;
    logic [3:0] m_y;

    task automatic add(input logic rst, en, sync, d,
                       input logic [3:0] y, input logic [1:0] s,
                       input logic v, l, e);
        vec_t t;
        t.rst = rst; t.en = en; t.sync = sync; t.d = d;
        t.y = y; t.s = s; t.v = v; t.l = l; t.e = e;
        vecs.push_back(t);
    endtask

    task automatic apply(input logic rst, en, sync, d, input exp_t x);
        exp_t g;
        @(negedge CLK);
        RST = rst; EN = en; SYNC = sync; D = d;
        sb.push_back(x);
        @(posedge CLK);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard empty");
        end else begin
            g = sb.pop_front();
            if ({Y, S, VALID, LOCK, ERR} !== {g.y, g.s, g.v, g.l, g.e}) begin
                errors++;
                $display("FAIL vec%0d got y=%b s=%0d v=%b l=%b e=%b want y=%b s=%0d v=%b l=%b e=%b",
                         g.id, Y, S, VALID, LOCK, ERR, g.y, g.s, g.v, g.l, g.e);
            end
        end
    endtask

    initial begin
        exp_t x;
        RST = 1'b1; EN = 1'b0; SYNC = 1'b0; D = 1'b0;

        // reset
        add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        // frame 1,1,0,0
        add(0, 1, 1, 1, 4'b0000, 1, 0, 1, 0);
        add(0, 1, 0, 1, 4'b0000, 2, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0000, 3, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0011, 0, 1, 1, 0);
        // back-to-back 0,0,1,0 then 1,0,0,0
        add(0, 1, 1, 0, 4'b0011, 1, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0011, 2, 0, 1, 0);
        add(0, 1, 0, 1, 4'b0011, 3, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0100, 0, 1, 1, 0);
        add(0, 1, 1, 1, 4'b0100, 1, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0100, 2, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0100, 3, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0001, 0, 1, 1, 0);
        // EN gap of 3 between slots 1 and 2; SYNC ignored while EN=0
        add(0, 1, 1, 1, 4'b0001, 1, 0, 1, 0);
        add(0, 1, 0, 1, 4'b0001, 2, 0, 1, 0);
        add(0, 0, 0, 1, 4'b0001, 2, 0, 1, 0);
        add(0, 0, 1, 1, 4'b0001, 2, 0, 1, 0);
        add(0, 0, 0, 0, 4'b0001, 2, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0001, 3, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0011, 0, 1, 1, 0);
        // early marker at S=2
        add(0, 1, 1, 0, 4'b0011, 1, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0011, 2, 0, 1, 0);
        add(0, 1, 1, 1, 4'b0011, 1, 0, 1, 1);
        add(0, 1, 0, 0, 4'b0011, 2, 0, 1, 0);
        add(0, 1, 0, 1, 4'b0011, 3, 0, 1, 0);
        add(0, 1, 0, 1, 4'b1101, 0, 1, 1, 0);
        // missing marker, hunt, EN=0 SYNC ignored, relock
        add(0, 1, 0, 1, 4'b1101, 0, 0, 0, 1);
        add(0, 1, 0, 0, 4'b1101, 0, 0, 0, 0);
        add(0, 0, 1, 1, 4'b1101, 0, 0, 0, 0);
        add(0, 1, 1, 0, 4'b1101, 1, 0, 1, 0);
        add(0, 1, 0, 1, 4'b1101, 2, 0, 1, 0);
        add(0, 1, 0, 1, 4'b1101, 3, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0110, 0, 1, 1, 0);
        // early marker at S=3
        add(0, 1, 1, 0, 4'b0110, 1, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0110, 2, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0110, 3, 0, 1, 0);
        add(0, 1, 1, 1, 4'b0110, 1, 0, 1, 1);
        add(0, 1, 0, 1, 4'b0110, 2, 0, 1, 0);
        add(0, 1, 0, 1, 4'b0110, 3, 0, 1, 0);
        add(0, 1, 0, 1, 4'b1111, 0, 1, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            x.y = vecs[i].y; x.s = vecs[i].s; x.v = vecs[i].v;
            x.l = vecs[i].l; x.e = vecs[i].e; x.id = i;
            apply(vecs[i].rst, vecs[i].en, vecs[i].sync, vecs[i].d, x);
        end

        // mid-frame reset at S=2, then hunt until a fresh SYNC
        x = '{y: 4'b1111, s: 1, v: 0, l: 1, e: 0, id: 100};
        apply(0, 1, 1, 1, x);
        x = '{y: 4'b1111, s: 2, v: 0, l: 1, e: 0, id: 101};
        apply(0, 1, 0, 1, x);
        x = '{y: 4'b0000, s: 0, v: 0, l: 0, e: 0, id: 102};
        apply(1, 1, 1, 1, x);
        x = '{y: 4'b0000, s: 0, v: 0, l: 0, e: 0, id: 103};
        apply(0, 1, 0, 1, x);
        x = '{y: 4'b0000, s: 1, v: 0, l: 1, e: 0, id: 104};
        apply(0, 1, 1, 1, x);
        x = '{y: 4'b0000, s: 2, v: 0, l: 1, e: 0, id: 105};
        apply(0, 1, 0, 0, x);
        x = '{y: 4'b0000, s: 3, v: 0, l: 1, e: 0, id: 106};
        apply(0, 1, 0, 1, x);
        x = '{y: 4'b1101, s: 0, v: 1, l: 1, e: 0, id: 107};
        apply(0, 1, 0, 1, x);

        // random stream against a behavioural model, starting from reset
        x = '{y: 4'b0000, s: 0, v: 0, l: 0, e: 0, id: 200};
        apply(1, 0, 0, 0, x);
        m_lock = 1'b0; m_s = 2'd0; m_sh = 3'b000; m_y = 4'b0000;
        for (int i = 0; i < 300; i++) begin
            logic en, sync, d, v, e;
            en   = ($urandom_range(0, 3) != 0);
            sync = (m_s == 2'd0) ? ($urandom_range(0, 9) < 8)
                                 : ($urandom_range(0, 9) == 0);
            d    = 1'($urandom_range(0, 1));
            v = 1'b0; e = 1'b0;
            if (en) begin
                if (!m_lock) begin
                    if (sync) begin
                        m_sh[0] = d; m_s = 2'd1; m_lock = 1'b1;
                    end
                end else if (sync) begin
                    e = (m_s != 2'd0);
                    m_sh[0] = d; m_s = 2'd1;
                end else if (m_s == 2'd0) begin
                    e = 1'b1; m_lock = 1'b0;
                end else if (m_s == 2'd3) begin
                    m_y = {d, m_sh[2], m_sh[1], m_sh[0]};
                    v = 1'b1; m_s = 2'd0;
                end else begin
                    m_sh[m_s] = d; m_s = m_s + 2'd1;
                end
            end
            x = '{y: m_y, s: m_s, v: v, l: m_lock, e: e, id: 300 + i};
            apply(0, en, sync, d, x);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
